// File: rtl/vx_ttu_request_arbiter.sv
// Round-robin front end that serialises scalar-core thread-transfer requests into the SIMT IRQC.
// Optional watchdog abort is compiled in with `define VX_TTU_REQ_TIMEOUT_EN.

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_ttu_request_arbiter #(
  parameter  int NUM_REQ     = 2,
  parameter  int WARP_CNT    = `NUM_WARPS,
  parameter  int THREAD_CNT  = `NUM_THREADS,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int WID_W       = (WARP_CNT   > 1) ? $clog2(WARP_CNT)   : 1,
  localparam int TID_W       = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1,
  localparam int SRC_W       = (NUM_REQ    > 1) ? $clog2(NUM_REQ)    : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][WID_W-1:0]        req_wid_i,
  input  logic [NUM_REQ-1:0][TID_W-1:0]        req_tid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [WARP_CNT-1:0][THREAD_CNT-1:0]  ttu_tid_mask_i,
  output logic                                 irq_valid_o,
  input  logic                                 irq_ready_i,
  output logic [WID_W-1:0]                     irq_wid_o,
  output logic [TID_W-1:0]                     irq_tid_o,
  input  logic                                 irq_done_i,
  input  logic                                 irq_nack_i,
  output logic                                 irq_abort_o,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [1:0]                           rsp_status_o,
  output logic                                 busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [WID_W-1:0]   wid_q, wid_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [1:0]         status_q, status_d;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  int                 cand;

`ifdef VX_TTU_REQ_TIMEOUT_EN
  localparam logic [12:0] WDOG_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wdog_q, wdog_d;
  logic        abort_q, abort_d;
  logic        timeout;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  // Scan requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[SRC_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    src_d        = src_q;
    wid_d        = wid_q;
    tid_d        = tid_q;
    status_d     = status_q;
    req_ready_o  = '0;
    irq_valid_o  = 1'b0;
    rsp_valid_o  = '0;
    rsp_status_o = ST_OK;
`ifdef VX_TTU_REQ_TIMEOUT_EN
    wdog_d       = wdog_q;
    abort_d      = 1'b0;
    timeout      = (wdog_q == WDOG_LAST);
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          src_d    = grant_idx;
          wid_d    = req_wid_i[grant_idx];
          tid_d    = req_tid_i[grant_idx];
          rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          // A cleared mask bit means the thread was already pulled; skip the IRQC.
          if (ttu_tid_mask_i[req_wid_i[grant_idx]][req_tid_i[grant_idx]]) begin
            state_d = ISSUE;
`ifdef VX_TTU_REQ_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            status_d = ST_REJECT;
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        irq_valid_o = 1'b1;
        if (irq_ready_i) state_d = WAIT;
`ifdef VX_TTU_REQ_TIMEOUT_EN
        wdog_d = wdog_q + 13'd1;
        if (timeout) begin
          status_d = ST_TIMEOUT;
          abort_d  = 1'b1;
          state_d  = RESP;
        end
`endif
      end
      WAIT: begin
`ifdef VX_TTU_REQ_TIMEOUT_EN
        wdog_d = wdog_q + 13'd1;
`endif
        if (irq_done_i) begin
          status_d = ST_OK;
          state_d  = RESP;
        end else if (irq_nack_i) begin
          status_d = ST_NACK;
          state_d  = RESP;
        end
`ifdef VX_TTU_REQ_TIMEOUT_EN
        else if (timeout) begin
          status_d = ST_TIMEOUT;
          abort_d  = 1'b1;
          state_d  = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid_o[src_q] = 1'b1;
        rsp_status_o       = status_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      wid_q    <= '0;
      tid_q    <= '0;
      status_q <= ST_OK;
`ifdef VX_TTU_REQ_TIMEOUT_EN
      wdog_q   <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      wid_q    <= wid_d;
      tid_q    <= tid_d;
      status_q <= status_d;
`ifdef VX_TTU_REQ_TIMEOUT_EN
      wdog_q   <= wdog_d;
      abort_q  <= abort_d;
`endif
    end
  end

  assign irq_wid_o = wid_q;
  assign irq_tid_o = tid_q;
  assign busy_o    = (state_q != IDLE);

`ifdef VX_TTU_REQ_TIMEOUT_EN
  assign irq_abort_o = abort_q;
`else
  assign irq_abort_o = 1'b0;
`endif

endmodule
